// File: rtl/pipe_result_accum_pkg.sv
// Shared types and defaults for the pipeline result accumulator.
package pipe_result_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam int unsigned DEF_DW  = 8;
  localparam int unsigned DEF_LAT = 3;
  localparam int unsigned DEF_N   = 4;
  localparam int unsigned DEF_SW  = 10;

  // Number of sign bits needed to widen a dw-bit value to sw bits.
  function automatic int unsigned extWidth(input int unsigned sw, input int unsigned dw);
    return sw - dw;
  endfunction

endpackage

// File: rtl/pipe_result_accum_if.sv
// Result stream in, block sum handshake out.
interface pipe_result_accum_if
  import pipe_result_accum_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned SW = DEF_SW
);
  logic [DW-1:0] din;
  logic          issue;
  logic          start;
  logic [SW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ack;
  logic          busy;
  logic          overrun;

  modport master (output din, issue, start, sum_ack,
                  input  sum_out, sum_valid, busy, overrun);
  modport slave  (input  din, issue, start, sum_ack,
                  output sum_out, sum_valid, busy, overrun);
endinterface

// File: rtl/pipe_result_accum_valid_delay_line.sv
// Latency-matched valid shift register: smp is issue delayed by LAT edges.
module valid_delay_line #(
  parameter int unsigned LAT = 3
) (
  input  logic clk,
  input  logic res,
  input  logic issue,
  output logic smp
);
  logic [LAT-1:0] v;

  generate
    if (LAT == 1) begin : gOne
      always_ff @(posedge clk) begin
        if (!res) v <= '0;
        else      v <= issue;
      end
    end else begin : gMany
      always_ff @(posedge clk) begin
        if (!res) v <= '0;
        else      v <= {v[LAT-2:0], issue};
      end
    end
  endgenerate

  assign smp = v[LAT-1];
endmodule

// File: rtl/pipe_result_accum.sv
// Sums N valid pipeline results per block and holds the sum on a valid/ack handshake.
module pipe_result_accum
  import pipe_result_accum_pkg::*;
#(
  parameter int unsigned DW  = DEF_DW,
  parameter int unsigned LAT = DEF_LAT,
  parameter int unsigned N   = DEF_N,
  parameter int unsigned SW  = DEF_SW
) (
  input logic               clk,
  input logic               res,
  pipe_result_accum_if.slave bus
);
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned EW = extWidth(SW, DW);

  state_t        state;
  logic [SW-1:0] acc;
  logic [SW-1:0] sumOut;
  logic [SW-1:0] dinExt;
  logic [CW-1:0] count;
  logic          sumValid;
  logic          busyQ;
  logic          overrunQ;
  logic          smp;

  valid_delay_line #(.LAT(LAT)) uDelay (
    .clk  (clk),
    .res  (res),
    .issue(bus.issue),
    .smp  (smp)
  );

  assign dinExt = {{EW{bus.din[DW-1]}}, bus.din};

  // Block FSM with accumulator; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!res) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      sumOut   <= '0;
      sumValid <= 1'b0;
      busyQ    <= 1'b0;
      overrunQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            overrunQ <= 1'b0;
            busyQ    <= 1'b1;
          end
        end
        ACCUM: begin
          if (smp) begin
            if (count == CW'(N - 1)) begin
              sumOut   <= acc + dinExt;
              sumValid <= 1'b1;
              state    <= HOLD;
              busyQ    <= 1'b0;
            end else begin
              acc   <= acc + dinExt;
              count <= count + CW'(1);
            end
          end
        end
        HOLD: begin
          // Samples in an ack cycle are dropped silently; otherwise they flag overrun.
          if (bus.sum_ack) begin
            sumValid <= 1'b0;
            if (bus.start) begin
              state    <= ACCUM;
              acc      <= '0;
              count    <= '0;
              overrunQ <= 1'b0;
              busyQ    <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (smp) begin
            overrunQ <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          sumValid <= 1'b0;
          busyQ    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sum_out   = sumOut;
  assign bus.sum_valid = sumValid;
  assign bus.busy      = busyQ;
  assign bus.overrun   = overrunQ;
endmodule
